// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the RV32E data-memory controller.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} dmem_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
  } dmem_req_t;

  function automatic int idx_bits(input int depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between the CPU's right-aligned data and the 32-bit RAM word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] wdata_rep,
  output logic [3:0]  be,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [7:0]  bsel;
  logic [15:0] hsel;

  assign bsel = rword[{addr_lo, 3'b000} +: 8];
  assign hsel = rword[{addr_lo[1], 4'b0000} +: 16];

  // Size 2'b11 falls into the word arm.
  always_comb begin
    wdata_rep  = '0;
    be         = '0;
    rdata_ext  = '0;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{bsel[7] & ~is_unsigned}}, bsel};
      end
      SZ_HALF: begin
        misaligned = addr_lo[0];
        be         = 4'b0011 << addr_lo;
        wdata_rep  = {2{wdata[15:0]}};
        rdata_ext  = {{16{hsel[15] & ~is_unsigned}}, hsel};
      end
      default: begin
        misaligned = |addr_lo;
        be         = 4'b1111;
        wdata_rep  = wdata;
        rdata_ext  = rword;
      end
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Load/store controller for the RV32E core: wait-stated handshake on step_en,
// lane alignment, misalignment rejection and a free-running debug word port.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step_en,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_unsigned,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        cpu_misaligned,
  input  logic        debug_en,
  input  logic        debug_we,
  input  logic [31:0] debug_addr,
  input  logic [31:0] debug_wdata,
  output logic [31:0] debug_rdata,
  output logic        debug_valid
);

  localparam int IW = idx_bits(DEPTH_WORDS);

  dmem_state_t state;
  logic [2:0]  wcnt;
  dmem_req_t   req;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [IW-1:0] cpu_idx, dbg_idx;
  logic [31:0]   rword, wr_data, ld_data;
  logic [3:0]    be;
  logic          mis, dbg_go, cpu_fire;

  assign cpu_idx  = req.addr[IW+1:2];
  assign dbg_idx  = debug_addr[IW+1:2];
  assign rword    = mem[cpu_idx];
  assign dbg_go   = (state == ST_IDLE) && debug_en;
  assign cpu_fire = step_en && (state == ST_WAIT) && (wcnt == 3'd0);

  // Address bits above the RAM window alias; low debug bits select nothing.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{debug_addr[31:IW+2], debug_addr[1:0], req.addr[31:IW+2]};

  dmem_lane_align u_align (
    .addr_lo    (req.addr[1:0]),
    .size       (req.size),
    .is_unsigned(req.uns),
    .wdata      (req.wdata),
    .rword      (rword),
    .wdata_rep  (wr_data),
    .be         (be),
    .rdata_ext  (ld_data),
    .misaligned (mis)
  );

  // RAM contents survive reset, but no write may land on a reset edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (dbg_go && debug_we)
        mem[dbg_idx] <= debug_wdata;
      else if (cpu_fire && req.we && !mis)
        for (int b = 0; b < 4; b++)
          if (be[b]) mem[cpu_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      wcnt           <= '0;
      req            <= '0;
      cpu_ready      <= 1'b0;
      cpu_misaligned <= 1'b0;
      cpu_rdata      <= '0;
      debug_valid    <= 1'b0;
      debug_rdata    <= '0;
    end else begin
      debug_valid <= dbg_go;
      if (dbg_go) debug_rdata <= mem[dbg_idx];
      if (step_en) begin
        case (state)
          ST_IDLE: if (cpu_req && !debug_en) begin
            req   <= '{we: cpu_we, addr: cpu_addr, size: cpu_size,
                       uns: cpu_unsigned, wdata: cpu_wdata};
            wcnt  <= 3'(WAIT_STATES);
            state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (wcnt != 3'd0) begin
              wcnt <= wcnt - 3'd1;
            end else begin
              cpu_ready      <= 1'b1;
              cpu_misaligned <= mis;
              cpu_rdata      <= (mis || req.we) ? 32'h0 : ld_data;
              state          <= ST_DONE;
            end
          end
          ST_DONE: begin
            cpu_ready      <= 1'b0;
            cpu_misaligned <= 1'b0;
            state          <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: two instances (0 and 3 wait states) against a byte-array model.
module tb_data_memory_ctrl;

  localparam int DW = 256;
  localparam int NB = DW * 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset[2], step_en[2], cpu_req[2], cpu_we[2], cpu_unsigned[2];
  logic        debug_en[2], debug_we[2];
  logic [31:0] cpu_addr[2], cpu_wdata[2], debug_addr[2], debug_wdata[2];
  logic [1:0]  cpu_size[2];
  logic [31:0] cpu_rdata[2], debug_rdata[2];
  logic        cpu_ready[2], cpu_misaligned[2], debug_valid[2];

  data_memory_ctrl #(.DEPTH_WORDS(DW), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset[0]), .step_en(step_en[0]), .cpu_req(cpu_req[0]),
    .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_size(cpu_size[0]),
    .cpu_unsigned(cpu_unsigned[0]), .cpu_wdata(cpu_wdata[0]), .cpu_rdata(cpu_rdata[0]),
    .cpu_ready(cpu_ready[0]), .cpu_misaligned(cpu_misaligned[0]), .debug_en(debug_en[0]),
    .debug_we(debug_we[0]), .debug_addr(debug_addr[0]), .debug_wdata(debug_wdata[0]),
    .debug_rdata(debug_rdata[0]), .debug_valid(debug_valid[0]));

  data_memory_ctrl #(.DEPTH_WORDS(DW), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(reset[1]), .step_en(step_en[1]), .cpu_req(cpu_req[1]),
    .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_size(cpu_size[1]),
    .cpu_unsigned(cpu_unsigned[1]), .cpu_wdata(cpu_wdata[1]), .cpu_rdata(cpu_rdata[1]),
    .cpu_ready(cpu_ready[1]), .cpu_misaligned(cpu_misaligned[1]), .debug_en(debug_en[1]),
    .debug_we(debug_we[1]), .debug_addr(debug_addr[1]), .debug_wdata(debug_wdata[1]),
    .debug_rdata(debug_rdata[1]), .debug_valid(debug_valid[1]));

  logic [7:0] mm [2][NB];
  int n_pass = 0;
  int n_chk  = 0;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [1:0]  s;
    logic        uns;
    logic [31:0] wd;
    logic [31:0] er;
    logic        em;
  } vec_t;

  function automatic int ws(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_mis(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'd1 && a[0]) || (s >= 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic int m_nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] m_load(input int d, input logic [31:0] a,
                                         input logic [1:0] s, input logic uns);
    longint v = 0;
    int n = m_nbytes(s);
    int base = int'(a) & (NB - 1);
    if (m_mis(a, s)) return 32'h0;
    for (int i = 0; i < n; i++) v += longint'(mm[d][base + i]) << (8 * i);
    if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  function automatic void m_store(input int d, input logic [31:0] a,
                                  input logic [1:0] s, input logic [31:0] wd);
    int base = int'(a) & (NB - 1);
    if (m_mis(a, s)) return;
    for (int i = 0; i < m_nbytes(s); i++) mm[d][base + i] = 8'(wd >> (8 * i));
  endfunction

  function automatic logic [31:0] m_word(input int d, input logic [31:0] a);
    logic [31:0] wa = a & 32'hFFFF_FFFC;
    return m_load(d, wa, 2'd2, 1'b0);
  endfunction

  // ---------------- drivers ----------------
  // mode 0: step_en always 1; 1: toggles 0,1,0,... after accept; 2: random
  task automatic cpu_op(input int d, input logic we, input logic [31:0] a, input logic [1:0] s,
                        input logic uns, input logic [31:0] wd, input int mode,
                        output logic [31:0] rd, output logic mis, output int nstep, output int lat);
    logic st;
    @(negedge clk);
    cpu_req[d] = 1'b1; cpu_we[d] = we; cpu_addr[d] = a; cpu_size[d] = s;
    cpu_unsigned[d] = uns; cpu_wdata[d] = wd; step_en[d] = 1'b1;
    @(posedge clk);
    nstep = 0; lat = 0; st = 1'b1;
    while (lat < 64) begin
      @(negedge clk);
      st = (mode == 0) ? 1'b1 : (mode == 1) ? !st : logic'($urandom % 2);
      step_en[d] = st;
      @(posedge clk); #1;
      lat++;
      if (st) nstep++;
      if (cpu_ready[d]) break;
    end
    rd = cpu_rdata[d]; mis = cpu_misaligned[d];
    if (mode != 0) begin
      @(negedge clk); step_en[d] = 1'b0;
      @(posedge clk); #1;
      chk("ready_hold_step_low", cpu_ready[d], 1'b1);
    end
    @(negedge clk); cpu_req[d] = 1'b0; step_en[d] = 1'b1;
    @(posedge clk); #1;
    chk("ready_drop", cpu_ready[d], 1'b0);
  endtask

  task automatic do_op(input int d, input logic we, input logic [31:0] a, input logic [1:0] s,
                       input logic uns, input logic [31:0] wd, input int mode);
    logic [31:0] rd, exp_rd;
    logic mis, exp_mis;
    int nstep, lat;
    exp_mis = m_mis(a, s);
    exp_rd  = we ? 32'h0 : m_load(d, a, s, uns);
    cpu_op(d, we, a, s, uns, wd, mode, rd, mis, nstep, lat);
    chk("model_misaligned", mis, exp_mis);
    if (!we || exp_mis) chk("model_rdata", rd, exp_rd);
    chk("model_step_latency", nstep, ws(d) + 1);
    if (mode == 0) chk("model_clk_latency", lat, ws(d) + 1);
    if (mode == 1) chk("toggle_clk_latency", lat, 2 * (ws(d) + 1));
    if (we) m_store(d, a, s, wd);
  endtask

  task automatic dbg_op(input int d, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic se);
    @(negedge clk);
    debug_en[d] = 1'b1; debug_we[d] = we; debug_addr[d] = a; debug_wdata[d] = wd;
    step_en[d] = se;
    @(posedge clk); #1;
    chk("dbg_valid", debug_valid[d], 1'b1);
    if (!we) chk("dbg_rdata", debug_rdata[d], m_word(d, a));
    else m_store(d, a & 32'hFFFF_FFFC, 2'd2, wd);
    @(negedge clk); debug_en[d] = 1'b0; step_en[d] = 1'b1;
    @(posedge clk); #1;
    chk("dbg_valid_drop", debug_valid[d], 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  vec_t tbl[18];

  initial begin
    logic [31:0] rd, a;
    logic [1:0]  s;
    logic        mis;
    int nstep, lat, nbad, early, cyc, bad_v, bad_r;

    tbl[0]  = '{1'b1, 32'h103, 2'd0, 1'b0, 32'h778899A5, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h103, 2'd0, 1'b0, 32'h0,        32'hFFFFFFA5, 1'b0};
    tbl[2]  = '{1'b0, 32'h103, 2'd0, 1'b1, 32'h0,        32'h000000A5, 1'b0};
    tbl[3]  = '{1'b0, 32'h100, 2'd2, 1'b0, 32'h0,        32'hA5000000, 1'b0};
    tbl[4]  = '{1'b1, 32'h00E, 2'd1, 1'b0, 32'h12348001, 32'h0,        1'b0};
    tbl[5]  = '{1'b0, 32'h00E, 2'd1, 1'b0, 32'h0,        32'hFFFF8001, 1'b0};
    tbl[6]  = '{1'b0, 32'h00E, 2'd1, 1'b1, 32'h0,        32'h00008001, 1'b0};
    tbl[7]  = '{1'b0, 32'h00C, 2'd2, 1'b0, 32'h0,        32'h80010000, 1'b0};
    tbl[8]  = '{1'b0, 32'h00F, 2'd0, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0};
    tbl[9]  = '{1'b0, 32'h006, 2'd2, 1'b0, 32'h0,        32'h0,        1'b1};
    tbl[10] = '{1'b1, 32'h004, 2'd2, 1'b0, 32'h11223344, 32'h0,        1'b0};
    tbl[11] = '{1'b1, 32'h006, 2'd2, 1'b0, 32'hFFFFFFFF, 32'h0,        1'b1};
    tbl[12] = '{1'b1, 32'h005, 2'd1, 1'b0, 32'h0000FFFF, 32'h0,        1'b1};
    tbl[13] = '{1'b0, 32'h004, 2'd3, 1'b0, 32'h0,        32'h11223344, 1'b0};
    tbl[14] = '{1'b0, 32'h007, 2'd0, 1'b0, 32'h0,        32'h00000011, 1'b0};
    tbl[15] = '{1'b0, 32'h006, 2'd1, 1'b0, 32'h0,        32'h00001122, 1'b0};
    tbl[16] = '{1'b0, 32'h005, 2'd0, 1'b1, 32'h0,        32'h00000033, 1'b0};
    tbl[17] = '{1'b0, 32'h105, 2'd1, 1'b0, 32'h0,        32'h0,        1'b1};

    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1; step_en[d] = 1'b1; cpu_req[d] = 1'b0; cpu_we[d] = 1'b0;
      cpu_unsigned[d] = 1'b0; cpu_addr[d] = '0; cpu_wdata[d] = '0; cpu_size[d] = '0;
      debug_en[d] = 1'b0; debug_we[d] = 1'b0; debug_addr[d] = '0; debug_wdata[d] = '0;
      for (int i = 0; i < NB; i++) mm[d][i] = 8'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_cpu_ready", cpu_ready[d], 1'b0);
      chk("rst_cpu_misaligned", cpu_misaligned[d], 1'b0);
      chk("rst_debug_valid", debug_valid[d], 1'b0);
      chk("rst_cpu_rdata", cpu_rdata[d], 32'h0);
      chk("rst_debug_rdata", debug_rdata[d], 32'h0);
    end
    @(negedge clk);
    reset[0] = 1'b0; reset[1] = 1'b0;

    // Clear both RAMs with back-to-back debug writes.
    nbad = 0;
    for (int i = 0; i < DW; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        debug_en[d] = 1'b1; debug_we[d] = 1'b1; debug_addr[d] = 32'(i * 4); debug_wdata[d] = 32'h0;
      end
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) if (debug_valid[d] !== 1'b1) nbad++;
    end
    @(negedge clk);
    debug_en[0] = 1'b0; debug_en[1] = 1'b0; debug_we[0] = 1'b0; debug_we[1] = 1'b0;
    chk("dbg_back_to_back_valid_misses", nbad, 0);

    // Directed vectors, zero wait states.
    foreach (tbl[k]) begin
      cpu_op(0, tbl[k].we, tbl[k].a, tbl[k].s, tbl[k].uns, tbl[k].wd, 0, rd, mis, nstep, lat);
      chk($sformatf("vec%0d_misaligned", k), mis, tbl[k].em);
      if (!tbl[k].we || tbl[k].em) chk($sformatf("vec%0d_rdata", k), rd, tbl[k].er);
      chk($sformatf("vec%0d_latency", k), lat, 1);
      if (tbl[k].we) m_store(0, tbl[k].a, tbl[k].s, tbl[k].wd);
    end

    // Debug preload while the CPU side is stalled, then wrapped loads.
    dbg_op(0, 1'b1, 32'h3FC, 32'hDEADBEEF, 1'b0);
    cpu_op(0, 1'b0, 32'h3FC, 2'd2, 1'b0, 32'h0, 0, rd, mis, nstep, lat);
    chk("preload_ld_3fc", rd, 32'hDEADBEEF);
    cpu_op(0, 1'b0, 32'h7FC, 2'd2, 1'b0, 32'h0, 0, rd, mis, nstep, lat);
    chk("preload_ld_7fc_wrap", rd, 32'hDEADBEEF);
    dbg_op(0, 1'b0, 32'h101, 32'h0, 1'b1);

    // Randomized traffic on the zero-wait instance.
    for (int n = 0; n < 150; n++) begin
      a = $urandom & 32'hFFFF_FC3F;
      s = 2'($urandom % 4);
      if ($urandom % 5 != 0) begin
        if (s == 2'd1) a[0] = 1'b0;
        if (s >= 2'd2) a[1:0] = 2'b00;
      end
      if ($urandom % 7 == 0) dbg_op(0, logic'($urandom % 2), a, $urandom, logic'($urandom % 2));
      else do_op(0, logic'($urandom % 2), a, s, logic'($urandom % 2), $urandom, 0);
    end

    // Three wait states with step_en toggling, then random step_en.
    do_op(1, 1'b1, 32'h20, 2'd2, 1'b0, 32'hCAFEF00D, 1);
    do_op(1, 1'b0, 32'h22, 2'd1, 1'b0, 32'h0, 1);
    for (int n = 0; n < 60; n++) begin
      a = $urandom & 32'hFFFF_FC3F;
      s = 2'($urandom % 4);
      if ($urandom % 5 != 0) begin
        if (s == 2'd1) a[0] = 1'b0;
        if (s >= 2'd2) a[1:0] = 2'b00;
      end
      if (a[5:2] == 4'd8 || a[5:2] == 4'd0) a[5:2] = 4'd1;  // keep 0x00/0x20 words intact
      do_op(1, logic'($urandom % 2), a, s, logic'($urandom % 2), $urandom, 2);
    end

    // Debug request arriving mid-transaction waits for IDLE.
    dbg_op(1, 1'b1, 32'h40, 32'h5555AAAA, 1'b1);
    @(negedge clk);
    cpu_req[1] = 1'b1; cpu_we[1] = 1'b0; cpu_addr[1] = 32'h20; cpu_size[1] = 2'd2;
    cpu_unsigned[1] = 1'b0; step_en[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    debug_en[1] = 1'b1; debug_we[1] = 1'b0; debug_addr[1] = 32'h40;
    early = 0; cyc = 0;
    while (cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
      if (debug_valid[1]) early++;
      if (cpu_ready[1]) break;
    end
    chk("arb_no_valid_during_wait", early, 0);
    chk("arb_cpu_latency", cyc, 4);
    chk("arb_cpu_rdata", cpu_rdata[1], 32'hCAFEF00D);
    @(negedge clk); cpu_req[1] = 1'b0;
    @(posedge clk); #1;
    chk("arb_no_valid_in_done", debug_valid[1], 1'b0);
    @(posedge clk); #1;
    chk("arb_valid_after_idle", debug_valid[1], 1'b1);
    chk("arb_debug_rdata", debug_rdata[1], 32'h5555AAAA);

    // Simultaneous request in IDLE: debug wins every cycle it is held.
    @(negedge clk);
    cpu_req[1] = 1'b1; cpu_addr[1] = 32'h40; debug_addr[1] = 32'h20;
    bad_v = 0; bad_r = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (debug_valid[1] !== 1'b1) bad_v++;
      if (cpu_ready[1] !== 1'b0) bad_r++;
    end
    chk("simul_debug_valid_misses", bad_v, 0);
    chk("simul_cpu_not_accepted", bad_r, 0);
    @(negedge clk); debug_en[1] = 1'b0;
    cyc = 0;
    while (cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
      if (cpu_ready[1]) break;
    end
    chk("simul_cpu_latency", cyc, 5);
    chk("simul_cpu_rdata", cpu_rdata[1], 32'h5555AAAA);
    @(negedge clk); cpu_req[1] = 1'b0;
    @(posedge clk);

    // Reset landing on the store's commit edge abandons it.
    @(negedge clk);
    cpu_req[1] = 1'b1; cpu_we[1] = 1'b1; cpu_addr[1] = 32'h20; cpu_size[1] = 2'd2;
    cpu_wdata[1] = 32'h0BADBAD0;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk); reset[1] = 1'b1; cpu_req[1] = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_no_ready", cpu_ready[1], 1'b0);
    chk("rst_mid_rdata", cpu_rdata[1], 32'h0);
    @(negedge clk); reset[1] = 1'b0;
    nbad = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (cpu_ready[1] !== 1'b0) nbad++;
    end
    chk("rst_mid_no_late_ready", nbad, 0);
    cpu_op(1, 1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 0, rd, mis, nstep, lat);
    chk("rst_mid_old_value", rd, 32'hCAFEF00D);
    chk("rst_mid_latency", lat, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Parametrised data-memory controller between the RV32E core's load/store port and an on-chip word RAM. It replaces bare RAM-plus-byte-enable logic with several functions:

- a req/ready handshake with configurable wait states;
- internal store lane alignment and load sign/zero extension;
- misalignment detection;
- a word-wide debug port for simulator-side preload and inspection.

The CPU side advances only on `step_en` cycles, which is a clock enable and not a gated clock. The debug side runs on every `clk`.

## Interface

Parameters:

- `DEPTH_WORDS`, 256 — RAM depth in 32-bit words; must be a power of two, ≥ 4.
- `WAIT_STATES`, 0 — extra step cycles before completion; range 0..7.

Ports (one clock; reset is synchronous and active-high):

- `clk` in 1 — single clock.
- `reset` in 1 — synchronous, active-high.
- `step_en` in 1 — CPU-side clock enable.
- `cpu_req` in 1 — access request; held stable until `cpu_ready`.
- `cpu_we` in 1 — 1 = store, 0 = load.
- `cpu_addr` in 32 — byte address.
- `cpu_size` in 2 — 00 byte, 01 half, 10 word; 11 is treated as word.
- `cpu_unsigned` in 1 — load zero-extends (LBU/LHU).
- `cpu_wdata` in 32 — store data, right-aligned (bits [7:0] for byte stores).
- `cpu_rdata` out 32 — extended load result.
- `cpu_ready` out 1 — one-step-cycle completion pulse.
- `cpu_misaligned` out 1 — qualifies `cpu_ready`; the access was rejected.
- `debug_en` in 1 — debug access request.
- `debug_we` in 1 — debug write.
- `debug_addr` in 32 — byte address; bits [1:0] are ignored.
- `debug_wdata` in 32 — full-word write data.
- `debug_rdata` out 32 — debug read word.
- `debug_valid` out 1 — debug access done, one `clk` pulse.

## Operation

- Word index is `addr[log2(DEPTH_WORDS)+1:2]`. Higher address bits are ignored, so addresses wrap modulo `DEPTH_WORDS*4`.
- **Misalignment:**
  - Half access with `addr[0]=1`, or word access with `addr[1:0]≠0`, is misaligned.
  - A misaligned access performs no RAM access.
  - It completes with `cpu_ready=1`, `cpu_misaligned=1` and `cpu_rdata=0`.
- **Store:**
  - Data is replicated into the addressed lane(s).
  - Byte enables: byte → `1<<addr[1:0]`; half → `4'b0011<<addr[1:0]`; word → `4'b1111`.
  - Only enabled bytes change.
- **Load:** the addressed byte or half is shifted to bit 0, then sign-extended unless `cpu_unsigned` is set. Word loads pass through unchanged.
- **FSM (`IDLE`, `WAIT`, `DONE`)** — CPU-side states advance only when `step_en=1`:
  - `IDLE` → `WAIT` when `cpu_req & step_en & ~debug_en`. The request is latched and the wait counter loads `WAIT_STATES`.
  - `WAIT`: while the counter ≠ 0, decrement it on each `step_en` cycle. When it is 0 on a `step_en` cycle, perform the RAM read or write, register the result, and go to `DONE`.
  - `DONE`: `cpu_ready` (plus `cpu_misaligned` if applicable) is high for exactly that state. Leave on the next `step_en` cycle to `IDLE`.
- **Debug arbitration:**
  - The debug port is serviced only in `IDLE`, on any `clk`, whatever the value of `step_en`.
  - While `debug_en=1`, new CPU requests are not accepted.
  - A debug request arriving mid-transaction waits until `IDLE`; `debug_valid` stays 0 during the wait.
  - Debug writes are full-word.
- Reset does not clear RAM contents. Simulation initialises the RAM to zero.

## Timing

- **Reset values:**
  - `cpu_ready`, `cpu_misaligned`, `debug_valid` = 0.
  - `cpu_rdata`, `debug_rdata` = 0.
  - FSM = `IDLE`; wait counter = 0; latched request cleared.
- **Reset mid-transaction:** the in-flight access is abandoned. A pending store is not written. No `cpu_ready` is issued.
- **CPU latency:** with all `step_en` = 1, `cpu_ready` is asserted `WAIT_STATES+1` `clk` cycles after the accept edge. With `WAIT_STATES=0`, that is the next cycle.
- **Store visibility:** the store is visible to a load accepted after its `DONE`.
- **`step_en` low:** state, counter and outputs hold. `cpu_ready` stays high until the next `step_en` cycle.
- **Debug latency:** `debug_valid` and `debug_rdata` are registered one `clk` after the request is sampled in `IDLE`. A debug write commits on that same edge.
- **Back-to-back debug:** a held `debug_en` is serviced every `clk`.
- **Simultaneous `cpu_req` and `debug_en` in `IDLE`:** debug wins.

## Structure

- **Package `dmem_pkg`:**
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - FSM state enum;
  - function `idx_bits(DEPTH_WORDS)`.
- **Sub-module `dmem_lane_align`:** combinational; covers store replication, byte-enable generation, load extraction/extension and the misalignment flag.
- **Top:** FSM, wait counter, RAM array and debug arbitration.

## Test plan

- **Byte store and loads:** `WAIT_STATES=0`. Store byte `0xA5` at `0x103`, then LB `0x103` → `0xFFFFFFA5`; LBU → `0x000000A5`; word `0x100` → `0xA5000000`. Each `cpu_ready` arrives 1 cycle after accept.
- **Half store and loads:** store half `0x8001` at `0x0E`, then LH → `0xFFFF8001`, LHU → `0x00008001`. Bytes `0x0C`–`0x0D` are unchanged.
- **Misaligned access:** word load at `0x06` → `cpu_ready=1`, `cpu_misaligned=1`, `rdata=0`, RAM unchanged.
- **Wait states and `step_en`:** `WAIT_STATES=3` with `step_en` toggling 1,0,1,0… → `ready` appears after 4 `step_en` cycles. State holds when `step_en=0`.
- **Debug preload:** debug write `0xDEADBEEF` to `0x3FC` while `step_en=0`. Then CPU word load `0x3FC` → `0xDEADBEEF`. Load from `0x7FC` (wrap) also → `0xDEADBEEF`.
- **Arbitration and reset:**
  - `debug_en` asserted during CPU `WAIT` → `debug_valid` only after `DONE`→`IDLE`.
  - Reset asserted in `WAIT` of a store → no write and no `ready`; a subsequent load returns the old value.
